pipe_elastic_stage: RTL and testbench
=====================================

Name: pipe_elastic_stage

Overview:
- Parametrised elastic pipeline stage that replaces fixed single-register stage latches between fetch/decode/execute/memory/writeback.
- Holds up to DEPTH in-flight instructions in a circular buffer with valid/ready handshakes on both sides.
- Carries an opaque stage payload plus writeback fields: dst, regwrite, ismem and result.
- Exposes NUM_Q forwarding query ports that search all held entries for the youngest pending write to a queried register.

Parameters:
- DEPTH, 2: buffer entries; ≥1, power of two.
- PAYLOAD_W, 256: width of opaque per-stage payload (pc, instr, ctl, csr, error ...).
- WORD_W, 64: result/forward data width.
- REG_W, 5: register address width.
- NUM_Q, 2: number of forwarding query ports.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  producer has an entry.
- in_ready  out  1  stage can accept.
- in_payload  in  PAYLOAD_W  opaque payload.
- in_dst  in  REG_W  destination register; 0 when no write.
- in_regwrite  in  1  entry writes a register.
- in_ismem  in  1  result is a load, data not yet valid.
- in_result  in  WORD_W  result/address word.
- out_valid  out  1  head entry available.
- out_ready  in  1  consumer accepts head.
- out_payload, out_dst, out_regwrite, out_ismem, out_result  out  as inputs  head entry fields.
- flush  in  1  discard all entries (branch mispredict/exception).
- q_addr  in  NUM_Q*REG_W  query register addresses, channel i at [i*REG_W +: REG_W].
- q_hit  out  NUM_Q  matching entry found.
- q_pending  out  NUM_Q  matching entry is ismem; requester must stall.
- q_data  out  NUM_Q*WORD_W  result of the matching entry.

Behaviour:
- State: DEPTH entry registers; head/tail pointers of log2(DEPTH) bits (1 bit min) wrapping modulo DEPTH; count of log2(DEPTH)+1 bits.
- Reset (async, any time including mid-transfer):
  - count=0, head=tail=0.
  - out_valid=0, in_ready=1, q_hit=0, q_pending=0, q_data=0.
  - Entry contents are don't-care but driven out as 0.
- in_ready = (count < DEPTH). Registered-state only; no combinational path from out_ready, so a full buffer never accepts in the same cycle it drains.
- Enqueue on edge when in_valid & in_ready & ~flush: write entry[tail], tail+1.
- Dequeue on edge when out_valid & out_ready: head+1.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- out_valid = (count != 0) & ~flush. out_* fields come directly from entry[head]; they are 0 when count=0.
- Latency: an entry accepted at edge N is visible on out_* after edge N; there is no same-cycle bypass.
- flush=1 at edge: count=0, head=tail=0. Enqueue and dequeue in that cycle are discarded. During the flush cycle q_hit/q_pending are forced to 0.
- Payload and data are held stable while out_valid & ~out_ready (no change until accepted).
- Forwarding, per channel i (combinational):
  - Candidates: valid entries with regwrite=1 and dst==q_addr[i].
  - q_addr[i]==0 never hits.
  - Select the youngest candidate, i.e. the one closest to tail, scanning across the wrap boundary correctly.
  - q_hit=1 when a candidate exists. q_data=its result. q_pending=its ismem.
  - No candidate: q_hit=0, q_pending=0, q_data=0.
  - The query never observes the entry being enqueued in the current cycle.

Test Plan:
- Reset mid-stream: fill 2 entries, assert reset asynchronously between edges -> out_valid=0, in_ready=1 immediately; q_hit=0.
- Single pass: enqueue dst=3, result=0x1234 with out_ready=1 -> out_valid=1 one cycle later with out_result=0x1234; then count returns to 0.
- Backpressure/full with DEPTH=2: out_ready=0, push A,B -> in_ready=0. Hold in_valid with C for 3 cycles -> C not taken and out shows A stable. Raise out_ready -> A, B, C delivered in order with no loss or duplication.
- Wrap-around: 10 pushes with alternating out_ready -> FIFO order preserved across pointer wrap; count never exceeds 2.
- Flush with simultaneous in_valid & out_ready on a full buffer -> next cycle count=0, out_valid=0, nothing delivered, new entry not stored.
- Forwarding: entries (older) dst=5 result=0xA ismem=0, (younger) dst=5 result=0xB ismem=1; q_addr={5,0} -> ch0 hit=1, data=0xB, pending=1; ch1 hit=0. Dequeue the older entry -> ch0 still 0xB. Query dst=7 with regwrite=0 -> hit=0.

Source files
------------

// File: rtl/pipe_elastic_stage_if.sv
// Handshake, writeback and forwarding bundle for one elastic pipeline stage.
// The producer/consumer/forwarding requester side uses the master modport;
// the stage itself uses the slave modport.
interface pipe_elastic_stage_if #(
  parameter int PAYLOAD_W = 256,
  parameter int WORD_W    = 64,
  parameter int REG_W     = 5,
  parameter int NUM_Q     = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [PAYLOAD_W-1:0]    in_payload;
  logic [REG_W-1:0]        in_dst;
  logic                    in_regwrite;
  logic                    in_ismem;
  logic [WORD_W-1:0]       in_result;

  logic                    out_valid;
  logic                    out_ready;
  logic [PAYLOAD_W-1:0]    out_payload;
  logic [REG_W-1:0]        out_dst;
  logic                    out_regwrite;
  logic                    out_ismem;
  logic [WORD_W-1:0]       out_result;

  logic                    flush;

  logic [NUM_Q*REG_W-1:0]  q_addr;
  logic [NUM_Q-1:0]        q_hit;
  logic [NUM_Q-1:0]        q_pending;
  logic [NUM_Q*WORD_W-1:0] q_data;

  modport master (
    output in_valid, in_payload, in_dst, in_regwrite, in_ismem, in_result,
    input  in_ready,
    input  out_valid, out_payload, out_dst, out_regwrite, out_ismem, out_result,
    output out_ready,
    output flush,
    output q_addr,
    input  q_hit, q_pending, q_data
  );

  modport slave (
    input  in_valid, in_payload, in_dst, in_regwrite, in_ismem, in_result,
    output in_ready,
    output out_valid, out_payload, out_dst, out_regwrite, out_ismem, out_result,
    input  out_ready,
    input  flush,
    input  q_addr,
    output q_hit, q_pending, q_data
  );
endinterface

// File: rtl/pipe_elastic_stage.sv
// Elastic pipeline stage: a DEPTH-entry circular buffer with valid/ready on
// both sides, carrying an opaque payload plus writeback fields, and NUM_Q
// combinational forwarding ports that return the youngest pending write to
// a queried register. DEPTH must be a power of two so pointers wrap freely.
module pipe_elastic_stage #(
  parameter int DEPTH     = 2,
  parameter int PAYLOAD_W = 256,
  parameter int WORD_W    = 64,
  parameter int REG_W     = 5,
  parameter int NUM_Q     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  pipe_elastic_stage_if.slave   bus
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [PTR_W-1:0]     head;
  logic [PTR_W-1:0]     tail;
  logic [CNT_W-1:0]     count;

  logic [PAYLOAD_W-1:0] mem_payload  [DEPTH];
  logic [REG_W-1:0]     mem_dst      [DEPTH];
  logic                 mem_regwrite [DEPTH];
  logic                 mem_ismem    [DEPTH];
  logic [WORD_W-1:0]    mem_result   [DEPTH];

  logic                 not_empty;
  logic                 do_enq;
  logic                 do_deq;

  logic [NUM_Q-1:0]        hit_v;
  logic [NUM_Q-1:0]        pend_v;
  logic [NUM_Q*WORD_W-1:0] data_v;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // in_ready depends only on registered occupancy, so a full stage never
  // accepts in the same cycle it drains; flush vetoes both transfers.
  assign not_empty     = (count != '0);
  assign bus.in_ready  = (count < CNT_W'(DEPTH));
  assign bus.out_valid = not_empty & ~bus.flush;
  assign do_enq        = bus.in_valid & bus.in_ready & ~bus.flush;
  assign do_deq        = bus.out_valid & bus.out_ready;

  assign bus.out_payload  = not_empty ? mem_payload[head]  : '0;
  assign bus.out_dst      = not_empty ? mem_dst[head]      : '0;
  assign bus.out_regwrite = not_empty ? mem_regwrite[head] : 1'b0;
  assign bus.out_ismem    = not_empty ? mem_ismem[head]    : 1'b0;
  assign bus.out_result   = not_empty ? mem_result[head]   : '0;

  assign bus.q_hit     = hit_v;
  assign bus.q_pending = pend_v;
  assign bus.q_data    = data_v;

  // Pointer and occupancy bookkeeping; flush empties the stage outright.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (bus.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (do_enq) begin
        tail <= ptr_inc(tail);
      end
      if (do_deq) begin
        head <= ptr_inc(head);
      end
      case ({do_enq, do_deq})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents of empty slots are never observed.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      mem_payload[tail]  <= bus.in_payload;
      mem_dst[tail]      <= bus.in_dst;
      mem_regwrite[tail] <= bus.in_regwrite;
      mem_ismem[tail]    <= bus.in_ismem;
      mem_result[tail]   <= bus.in_result;
    end
  end

  // Forwarding search: walk entries oldest to youngest from head so the last
  // match wins, which handles the wrap boundary without special cases.
  always_comb begin
    hit_v  = '0;
    pend_v = '0;
    data_v = '0;
    for (int ch = 0; ch < NUM_Q; ch++) begin
      logic [REG_W-1:0] addr;
      logic [PTR_W-1:0] idx;
      addr = bus.q_addr[ch*REG_W +: REG_W];
      idx  = head;
      for (int k = 0; k < DEPTH; k++) begin
        idx = head + PTR_W'(k);
        if ((CNT_W'(k) < count) && mem_regwrite[idx] &&
            (mem_dst[idx] == addr) && (addr != '0)) begin
          hit_v[ch]                   = 1'b1;
          pend_v[ch]                  = mem_ismem[idx];
          data_v[ch*WORD_W +: WORD_W] = mem_result[idx];
        end
      end
      if (bus.flush) begin
        hit_v[ch]                   = 1'b0;
        pend_v[ch]                  = 1'b0;
        data_v[ch*WORD_W +: WORD_W] = '0;
      end
    end
  end

endmodule

// File: tb/tb_pipe_elastic_stage.sv
// Self-checking bench for pipe_elastic_stage: a queue-based reference model
// tracks held entries; forwarding is the youngest matching queue element.
module tb_pipe_elastic_stage;

  localparam int DEPTH     = 2;
  localparam int PAYLOAD_W = 256;
  localparam int WORD_W    = 64;
  localparam int REG_W     = 5;
  localparam int NUM_Q     = 2;

  typedef struct packed {
    logic [PAYLOAD_W-1:0] payload;
    logic [REG_W-1:0]     dst;
    logic                 regwrite;
    logic                 ismem;
    logic [WORD_W-1:0]    result;
  } entry_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  entry_t model_q[$];

  pipe_elastic_stage_if #(.PAYLOAD_W(PAYLOAD_W), .WORD_W(WORD_W),
                          .REG_W(REG_W), .NUM_Q(NUM_Q)) bus();

  pipe_elastic_stage #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W), .WORD_W(WORD_W),
                       .REG_W(REG_W), .NUM_Q(NUM_Q)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Safety net so the run always terminates
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [PAYLOAD_W-1:0] rand_payload();
    logic [PAYLOAD_W-1:0] p;
    for (int i = 0; i < PAYLOAD_W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic entry_t mk_entry(input logic [REG_W-1:0] d, input logic [WORD_W-1:0] r,
                                      input logic rw, input logic im);
    entry_t e;
    e.payload = rand_payload();
    e.dst = d; e.result = r; e.regwrite = rw; e.ismem = im;
    return e;
  endfunction

  function automatic entry_t rand_entry();
    return mk_entry(REG_W'($urandom_range(0, 7)), {$urandom, $urandom},
                    1'($urandom), 1'($urandom));
  endfunction

  // Youngest held entry that writes register a; nothing during a flush
  function automatic void model_fwd(input logic [REG_W-1:0] a, output logic h,
                                    output logic p, output logic [WORD_W-1:0] d);
    h = 1'b0; p = 1'b0; d = '0;
    if (bus.flush || a == '0) return;
    for (int i = model_q.size() - 1; i >= 0; i--) begin
      if (model_q[i].regwrite && model_q[i].dst == a) begin
        h = 1'b1; p = model_q[i].ismem; d = model_q[i].result;
        return;
      end
    end
  endfunction

  task automatic drive(input logic v, input entry_t e, input logic ordy, input logic fl);
    bus.in_valid    = v;
    bus.in_payload  = e.payload;
    bus.in_dst      = e.dst;
    bus.in_regwrite = e.regwrite;
    bus.in_ismem    = e.ismem;
    bus.in_result   = e.result;
    bus.out_ready   = ordy;
    bus.flush       = fl;
  endtask

  // Apply the transfer rules to the model, then take one clock edge
  task automatic advance();
    entry_t cur;
    bit enq, deq;
    cur = '{payload: bus.in_payload, dst: bus.in_dst, regwrite: bus.in_regwrite,
            ismem: bus.in_ismem, result: bus.in_result};
    enq = bus.in_valid && (model_q.size() < DEPTH) && !bus.flush;
    deq = (model_q.size() != 0) && !bus.flush && bus.out_ready;
    if (bus.flush) model_q.delete();
    else begin
      if (deq) void'(model_q.pop_front());
      if (enq) model_q.push_back(cur);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    entry_t e;
    reset = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    bus.q_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.q_hit !== '0 || bus.q_data !== '0 || bus.q_pending !== '0) begin n_fail++; $display("[TB] FAIL reset_query: got hit %b data %0h expected 0", bus.q_hit, bus.q_data); end
    n_checks++;
    if (bus.out_result !== '0) begin n_fail++; $display("[TB] FAIL reset_out_result: got %0h expected 0", bus.out_result); end
    reset = 1'b0;
    model_q.delete();
    @(posedge clk); #1;

    // Mid-stream: two held entries, then an async reset between edges
    e = mk_entry(5'd4, 64'h44, 1'b1, 1'b0);
    drive(1'b1, e, 1'b0, 1'b0); advance();
    e = mk_entry(5'd4, 64'h45, 1'b1, 1'b0);
    drive(1'b1, e, 1'b0, 1'b0); advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    bus.q_addr = {5'd0, 5'd4};
    #2;
    n_checks++;
    if (bus.in_ready !== 1'b0 || bus.q_hit[0] !== 1'b1) begin n_fail++; $display("[TB] FAIL prereset_full: got ready %b hit %b expected 0 1", bus.in_ready, bus.q_hit[0]); end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL midreset_in_ready: got %b expected 1", bus.in_ready); end
    n_checks++;
    if (bus.q_hit !== '0) begin n_fail++; $display("[TB] FAIL midreset_q_hit: got %b expected 0", bus.q_hit); end
    #1;
    reset = 1'b0;
    model_q.delete();
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL postreset_out_valid: got %b expected 0", bus.out_valid); end
  endtask

  task automatic test_single_pass();
    entry_t e;
    e = mk_entry(5'd3, 64'h1234, 1'b1, 1'b0);
    drive(1'b1, e, 1'b1, 1'b0);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL single_no_bypass: got %b expected 0", bus.out_valid); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.out_result !== 64'h1234 || bus.out_dst !== 5'd3) begin
      n_fail++; $display("[TB] FAIL single_out: got valid %b result %0h dst %0d expected 1 1234 3", bus.out_valid, bus.out_result, bus.out_dst);
    end
    n_checks++;
    if (bus.out_payload !== e.payload || bus.out_regwrite !== 1'b1) begin n_fail++; $display("[TB] FAIL single_payload: got %0h expected %0h", bus.out_payload, e.payload); end
    advance();
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL single_drained: got valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
  endtask

  task automatic test_backpressure();
    entry_t exp_list[3];
    int delivered = 0;
    bit c_sent = 0;
    for (int i = 0; i < 3; i++) exp_list[i] = rand_entry();
    drive(1'b1, exp_list[0], 1'b0, 1'b0); advance();
    drive(1'b1, exp_list[1], 1'b0, 1'b0); advance();
    drive(1'b1, exp_list[2], 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      #2;
      n_checks++;
      if (bus.in_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_in_ready: got %b expected 0", bus.in_ready); end
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== exp_list[0].result || bus.out_payload !== exp_list[0].payload) begin
        n_fail++; $display("[TB] FAIL bp_head_stable: got %0h expected %0h", bus.out_result, exp_list[0].result);
      end
      advance();
    end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 10 && (delivered < 3 || model_q.size() != 0); c++) begin
      #2;
      if (bus.out_valid === 1'b1) begin
        n_checks++;
        if (delivered >= 3 || bus.out_result !== exp_list[delivered].result) begin
          n_fail++; $display("[TB] FAIL bp_order: got %0h at delivery %0d", bus.out_result, delivered);
        end
        delivered++;
      end
      if (!c_sent && model_q.size() < DEPTH) begin
        c_sent = 1;
        advance();
        bus.in_valid = 1'b0;
      end else begin
        advance();
      end
    end
    n_checks++;
    if (delivered != 3) begin n_fail++; $display("[TB] FAIL bp_count: got %0d expected 3", delivered); end
  endtask

  task automatic test_wrap();
    entry_t e;
    int pushed = 0, delivered = 0;
    e = rand_entry();
    for (int c = 0; c < 60 && (pushed < 10 || model_q.size() != 0); c++) begin
      drive(pushed < 10, e, 1'(c % 2), 1'b0);
      #2;
      n_checks++;
      if (bus.out_valid !== (model_q.size() != 0) || bus.in_ready !== (model_q.size() < DEPTH)) begin
        n_fail++; $display("[TB] FAIL wrap_flags: got valid %b ready %b expected size %0d", bus.out_valid, bus.in_ready, model_q.size());
      end
      if (model_q.size() != 0) begin
        n_checks++;
        if (bus.out_result !== model_q[0].result || bus.out_payload !== model_q[0].payload) begin
          n_fail++; $display("[TB] FAIL wrap_order: got %0h expected %0h", bus.out_result, model_q[0].result);
        end
        if (bus.out_ready) delivered++;
      end
      if (pushed < 10 && model_q.size() < DEPTH) begin
        pushed++;
        advance();
        e = rand_entry();
      end else begin
        advance();
      end
    end
    n_checks++;
    if (delivered != 10) begin n_fail++; $display("[TB] FAIL wrap_count: got %0d expected 10", delivered); end
  endtask

  task automatic test_flush();
    entry_t e;
    e = mk_entry(5'd6, 64'h66, 1'b1, 1'b0);
    drive(1'b1, e, 1'b0, 1'b0); advance();
    drive(1'b1, e, 1'b0, 1'b0); advance();
    bus.q_addr = {5'd0, 5'd6};
    e = mk_entry(5'd6, 64'h77, 1'b1, 1'b1);
    drive(1'b1, e, 1'b1, 1'b1);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL flush_out_valid: got %b expected 0", bus.out_valid); end
    n_checks++;
    if (bus.q_hit !== '0 || bus.q_pending !== '0) begin n_fail++; $display("[TB] FAIL flush_query: got hit %b pend %b expected 0", bus.q_hit, bus.q_pending); end
    advance();
    drive(1'b0, '0, 1'b1, 1'b0);
    #2;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL postflush_empty: got valid %b ready %b expected 0 1", bus.out_valid, bus.in_ready); end
    n_checks++;
    if (bus.q_hit[0] !== 1'b0) begin n_fail++; $display("[TB] FAIL postflush_not_stored: got hit %b expected 0", bus.q_hit[0]); end
    advance();
  endtask

  task automatic test_forwarding();
    drive(1'b1, mk_entry(5'd5, 64'hA, 1'b1, 1'b0), 1'b0, 1'b0); advance();
    drive(1'b1, mk_entry(5'd5, 64'hB, 1'b1, 1'b1), 1'b0, 1'b0); advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    bus.q_addr = {5'd0, 5'd5};
    #2;
    n_checks++;
    if (bus.q_hit[0] !== 1'b1 || bus.q_data[0 +: WORD_W] !== 64'hB || bus.q_pending[0] !== 1'b1) begin
      n_fail++; $display("[TB] FAIL fwd_youngest: got hit %b data %0h pend %b expected 1 b 1", bus.q_hit[0], bus.q_data[0 +: WORD_W], bus.q_pending[0]);
    end
    n_checks++;
    if (bus.q_hit[1] !== 1'b0 || bus.q_data[WORD_W +: WORD_W] !== '0) begin
      n_fail++; $display("[TB] FAIL fwd_reg0: got hit %b data %0h expected 0 0", bus.q_hit[1], bus.q_data[WORD_W +: WORD_W]);
    end
    bus.out_ready = 1'b1; advance();
    bus.out_ready = 1'b0;
    #2;
    n_checks++;
    if (bus.q_hit[0] !== 1'b1 || bus.q_data[0 +: WORD_W] !== 64'hB) begin
      n_fail++; $display("[TB] FAIL fwd_after_deq: got hit %b data %0h expected 1 b", bus.q_hit[0], bus.q_data[0 +: WORD_W]);
    end
    drive(1'b1, mk_entry(5'd7, 64'hC, 1'b0, 1'b0), 1'b0, 1'b0);
    bus.q_addr = {5'd7, 5'd5};
    advance();
    drive(1'b0, '0, 1'b0, 1'b0);
    #2;
    n_checks++;
    if (bus.q_hit[1] !== 1'b0) begin n_fail++; $display("[TB] FAIL fwd_no_regwrite: got hit %b expected 0", bus.q_hit[1]); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 6 && model_q.size() != 0; c++) advance();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random_traffic();
    logic h, p;
    logic [WORD_W-1:0] d;
    logic [REG_W-1:0]  a;
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom), rand_entry(), 1'($urandom), ($urandom_range(0, 15) == 0));
      for (int ch = 0; ch < NUM_Q; ch++) bus.q_addr[ch*REG_W +: REG_W] = REG_W'($urandom_range(0, 7));
      #2;
      n_checks++;
      if (bus.out_valid !== (model_q.size() != 0 && !bus.flush) || bus.in_ready !== (model_q.size() < DEPTH)) begin
        n_fail++; $display("[TB] FAIL rand_flags: got valid %b ready %b expected size %0d flush %b", bus.out_valid, bus.in_ready, model_q.size(), bus.flush);
      end
      n_checks++;
      if (bus.out_result !== ((model_q.size() != 0) ? model_q[0].result : '0)) begin
        n_fail++; $display("[TB] FAIL rand_head: got %0h", bus.out_result);
      end
      for (int ch = 0; ch < NUM_Q; ch++) begin
        a = bus.q_addr[ch*REG_W +: REG_W];
        model_fwd(a, h, p, d);
        n_checks++;
        if (bus.q_hit[ch] !== h || bus.q_pending[ch] !== p ||
            (!bus.flush && bus.q_data[ch*WORD_W +: WORD_W] !== d)) begin
          n_fail++; $display("[TB] FAIL rand_fwd ch%0d addr %0d: got hit %b pend %b data %0h expected %b %b %0h",
                             ch, a, bus.q_hit[ch], bus.q_pending[ch], bus.q_data[ch*WORD_W +: WORD_W], h, p, d);
        end
      end
      advance();
    end
  endtask

  initial begin
    $display("[TB] starting pipe_elastic_stage bench");
    test_reset();
    test_single_pass();
    test_backpressure();
    test_wrap();
    test_flush();
    test_forwarding();
    test_random_traffic();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
